// File: rtl/bd_rx_core_if.sv
// rtl/bd_rx_core_if.sv - host register bus and interrupt for bd_rx_core
interface bd_rx_core_if;
    logic [7:0] ADDRESS;
    logic [7:0] DATA_IN;
    logic       write_enable;
    logic       read_enable;
    logic [7:0] DATA_OUT;
    logic       int_rx_host;

    modport master (
        output ADDRESS, DATA_IN, write_enable, read_enable,
        input  DATA_OUT, int_rx_host
    );

    modport slave (
        input  ADDRESS, DATA_IN, write_enable, read_enable,
        output DATA_OUT, int_rx_host
    );
endinterface

// File: rtl/bd_rx_core.sv
// rtl/bd_rx_core.sv - baseband receive core: majority slicer, sync hunt, framer, frame FIFO, host registers
module bd_rx_core #(
    parameter int ADC_W      = 8,
    parameter int OVERSAMPLE = 8,
    parameter int FRAME_BITS = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             G_CLK_RX,
    input  logic             reset,
    input  logic [ADC_W-1:0] ADC,
    bd_rx_core_if.slave      bus
);
    localparam int PHW = $clog2(OVERSAMPLE);
    localparam int HTW = $clog2(OVERSAMPLE + 1);
    localparam int PTW = $clog2(FIFO_DEPTH);
    localparam logic [PHW-1:0] PHASE_LAST = PHW'(OVERSAMPLE - 1);
    localparam logic [HTW-1:0] HIT_HALF   = HTW'(OVERSAMPLE / 2);
    localparam logic [PTW-1:0] PTR_LAST   = PTW'(FIFO_DEPTH - 1);
    localparam logic [3:0]     DEPTH      = 4'(FIFO_DEPTH);
    localparam logic [4:0]     BIT_LAST   = 5'(FRAME_BITS - 1);

    typedef enum logic [1:0] {IDLE, HUNT, DATA} state_t;

    logic             rx_enable, int_en;
    logic [7:0]       thresh, sync_byte;
    logic [PHW-1:0]   phase;
    logic [HTW-1:0]   hits;
    logic             bit_valid, sliced_bit;
    state_t           state, state_nx;
    logic [7:0]       shreg, shreg_nx;
    logic [15:0]      word, word_nx;
    logic [4:0]       bcnt, bcnt_nx;
    logic             push;
    logic [15:0]      mem [FIFO_DEPTH];
    logic [PTW-1:0]   wr_ptr, rd_ptr;
    logic [3:0]       count;
    logic             overflow;
    logic [7:0]       rd_data;

    // FLUSH is never stored; it acts only in the cycle of the CTRL write
    logic wr_ctrl, flush, ovf_clr, hit, not_empty, full, pop_req, push_ok;
    logic [HTW-1:0] hits_next;
    logic [15:0]    head;
    assign wr_ctrl   = bus.write_enable && (bus.ADDRESS == 8'h00);
    assign flush     = wr_ctrl && bus.DATA_IN[2];
    assign ovf_clr   = bus.write_enable && (bus.ADDRESS == 8'h01) && bus.DATA_IN[2];
    assign hit       = (ADC[ADC_W-1 -: 8] >= thresh);
    assign hits_next = hits + HTW'(hit);
    assign not_empty = (count != 4'd0);
    assign full      = (count == DEPTH);
    assign pop_req   = bus.read_enable && (bus.ADDRESS == 8'h05) && not_empty;
    assign push_ok   = push && (!full || pop_req);
    assign head      = mem[rd_ptr];

    function automatic logic [PTW-1:0] ptr_inc(input logic [PTW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // host-writable configuration registers
    always_ff @(posedge G_CLK_RX or negedge reset) begin
        if (!reset) begin
            rx_enable <= 1'b0;
            int_en    <= 1'b0;
            thresh    <= 8'h80;
            sync_byte <= 8'hA5;
        end else if (bus.write_enable) begin
            case (bus.ADDRESS)
                8'h00: begin
                    rx_enable <= bus.DATA_IN[0];
                    int_en    <= bus.DATA_IN[1];
                end
                8'h02:   thresh    <= bus.DATA_IN;
                8'h03:   sync_byte <= bus.DATA_IN;
                default: ;
            endcase
        end
    end

    // majority-vote slicer; held at phase 0 while disabled so enabling restarts the bit grid
    always_ff @(posedge G_CLK_RX or negedge reset) begin
        if (!reset) begin
            phase      <= '0;
            hits       <= '0;
            bit_valid  <= 1'b0;
            sliced_bit <= 1'b0;
        end else begin
            bit_valid <= 1'b0;
            if (!rx_enable) begin
                phase <= '0;
                hits  <= '0;
            end else if (phase == PHASE_LAST) begin
                phase      <= '0;
                hits       <= '0;
                bit_valid  <= 1'b1;
                sliced_bit <= (hits_next > HIT_HALF);
            end else begin
                phase <= phase + 1'b1;
                hits  <= hits_next;
            end
        end
    end

    // framer state register
    always_ff @(posedge G_CLK_RX or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            shreg <= '0;
            word  <= '0;
            bcnt  <= '0;
        end else begin
            state <= state_nx;
            shreg <= shreg_nx;
            word  <= word_nx;
            bcnt  <= bcnt_nx;
        end
    end

    // framer next state: hunt for sync at the LSB, then collect the payload MSB first
    always_comb begin
        state_nx = state;
        shreg_nx = shreg;
        word_nx  = word;
        bcnt_nx  = bcnt;
        push     = 1'b0;
        if (!rx_enable) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_nx = HUNT;
                    shreg_nx = '0;
                end
                HUNT: begin
                    if (flush) begin
                        shreg_nx = '0;
                    end else if (bit_valid) begin
                        shreg_nx = {shreg[6:0], sliced_bit};
                        if ({shreg[6:0], sliced_bit} == sync_byte) begin
                            state_nx = DATA;
                            bcnt_nx  = '0;
                            word_nx  = '0;
                        end
                    end
                end
                DATA: begin
                    if (flush) begin
                        state_nx = HUNT;
                        shreg_nx = '0;
                    end else if (bit_valid) begin
                        word_nx = {word[14:0], sliced_bit};
                        bcnt_nx = bcnt + 5'd1;
                        if (bcnt == BIT_LAST) begin
                            push     = 1'b1;
                            state_nx = HUNT;
                            shreg_nx = '0;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // frame storage; contents are only meaningful between rd_ptr and wr_ptr
    always_ff @(posedge G_CLK_RX) begin
        if (push_ok && !flush)
            mem[wr_ptr] <= word_nx;
    end

    // FIFO pointers, occupancy and sticky overflow; flush beats push and pop
    always_ff @(posedge G_CLK_RX or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
                if (pop_req) rd_ptr <= ptr_inc(rd_ptr);
                count <= count + 4'(push_ok) - 4'(pop_req);
            end
            if (push && full && !pop_req && !flush)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

    // read mux; an empty FIFO reads as zero rather than stale storage
    always_comb begin
        rd_data = 8'h00;
        case (bus.ADDRESS)
            8'h00:   rd_data = {6'b0, int_en, rx_enable};
            8'h01:   rd_data = {count, 1'b0, overflow, full, not_empty};
            8'h02:   rd_data = thresh;
            8'h03:   rd_data = sync_byte;
            8'h04:   rd_data = not_empty ? head[7:0]  : 8'h00;
            8'h05:   rd_data = not_empty ? head[15:8] : 8'h00;
            default: rd_data = 8'h00;
        endcase
    end

    // registered read data and interrupt
    always_ff @(posedge G_CLK_RX or negedge reset) begin
        if (!reset) begin
            bus.DATA_OUT    <= 8'h00;
            bus.int_rx_host <= 1'b0;
        end else begin
            bus.DATA_OUT    <= rd_data;
            bus.int_rx_host <= int_en & (not_empty | overflow);
        end
    end
endmodule

// File: tb/tb_bd_rx_core.sv
// tb/tb_bd_rx_core.sv - randomized directed bench for bd_rx_core with a frame-queue reference model
module tb_bd_rx_core;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] adc = 8'h00;

    bd_rx_core_if bus();

    bd_rx_core #(.ADC_W(8), .OVERSAMPLE(8), .FRAME_BITS(16), .FIFO_DEPTH(4)) dut (
        .G_CLK_RX (clk),
        .reset    (rst_n),
        .ADC      (adc),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] model_q[$];
    logic        model_ovf = 1'b0;
    logic [7:0]  thr = 8'h80;
    logic        lo_bf = 1'b0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_status();
        int n = model_q.size();
        return {4'(n), 1'b0, model_ovf, (n == 4), (n != 0)};
    endfunction

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.ADDRESS = a; bus.DATA_IN = d; bus.write_enable = 1'b1;
        @(negedge clk);
        bus.write_enable = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
        @(negedge clk);
        bus.ADDRESS = a; bus.read_enable = 1'b1;
        @(negedge clk);
        bus.read_enable = 1'b0;
        check(tag, bus.DATA_OUT, exp);
    endtask

    // disable then enable so the slicer bit grid starts with the next sample
    task automatic restart(input logic [7:0] ctrl);
        wr(8'h00, 8'h00);
        wr(8'h00, ctrl);
    endtask

    // one bit period with exactly 'highs' samples at/above threshold in random positions
    task automatic send_bit(input int highs);
        int rem = highs;
        for (int s = 0; s < 8; s++) begin
            logic h = ($urandom_range(7 - s, 0) < rem);
            if (h) rem--;
            if (h) adc = 8'($urandom_range(255, int'(thr)));
            else   adc = lo_bf ? 8'hBF : 8'($urandom_range(int'(thr) - 1, 0));
            @(negedge clk);
        end
    endtask

    task automatic send_bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--)
            send_bit(v[i] ? int'($urandom_range(8, 5)) : int'($urandom_range(4, 0)));
    endtask

    task automatic send_frame(input logic [15:0] w);
        send_bits(16'h0000, 2);
        send_bits(16'h00A5, 8);
        send_bits(w, 16);
        adc = 8'h00;
    endtask

    task automatic model_push(input logic [15:0] w);
        if (model_q.size() < 4) model_q.push_back(w);
        else model_ovf = 1'b1;
    endtask

    task automatic pop_chk(input string tag);
        rd_chk({tag, "_lo"}, 8'h04, model_q[0][7:0]);
        rd_chk({tag, "_hi"}, 8'h05, model_q[0][15:8]);
        void'(model_q.pop_front());
    endtask

    initial begin
        logic [15:0] w;
        int          wait_n;
        bus.ADDRESS = 8'h00; bus.DATA_IN = 8'h00;
        bus.write_enable = 1'b0; bus.read_enable = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_int", bus.int_rx_host, 1'b0);
        rst_n = 1'b1;

        rd_chk("rst_ctrl",   8'h00, 8'h00);
        rd_chk("rst_status", 8'h01, 8'h00);
        rd_chk("rst_thresh", 8'h02, 8'h80);
        rd_chk("rst_sync",   8'h03, 8'hA5);
        rd_chk("rst_lo",     8'h04, 8'h00);
        rd_chk("rst_hi",     8'h05, 8'h00);
        rd_chk("rst_unmap",  8'h07, 8'h00);
        check("rst_int2", bus.int_rx_host, 1'b0);

        // basic frame and interrupt
        restart(8'h03);
        send_frame(16'h1234);
        model_push(16'h1234);
        wait_n = 0;
        while (!bus.int_rx_host && wait_n < 2) begin
            @(negedge clk);
            wait_n++;
        end
        check("int_after_frame", bus.int_rx_host, 1'b1);
        rd_chk("status_one", 8'h01, exp_status());
        pop_chk("frame1234");
        rd_chk("status_drained", 8'h01, exp_status());
        check("int_cleared", bus.int_rx_host, 1'b0);

        // majority boundary: random hit counts, first two bits forced to 4 and 5 hits
        restart(8'h03);
        send_bits(16'h0000, 2);
        send_bits(16'h00A5, 8);
        w = '0;
        for (int i = 0; i < 16; i++) begin
            int highs = (i == 0) ? 4 : (i == 1) ? 5 : int'($urandom_range(8, 0));
            w = {w[14:0], (highs > 4)};
            send_bit(highs);
        end
        adc = 8'h00;
        model_push(w);
        rd_chk("status_major", 8'h01, exp_status());
        pop_chk("majority");

        // raised threshold with lows pinned just below it
        wr(8'h00, 8'h00);
        wr(8'h02, 8'hC0);
        thr = 8'hC0;
        lo_bf = 1'b1;
        restart(8'h03);
        w = 16'($urandom);
        send_frame(w);
        model_push(w);
        lo_bf = 1'b0;
        rd_chk("thresh_read", 8'h02, 8'hC0);
        pop_chk("thresh");
        wr(8'h02, 8'h80);
        thr = 8'h80;

        // overflow with interrupts masked
        restart(8'h01);
        for (int f = 0; f < 5; f++) begin
            w = 16'($urandom);
            send_frame(w);
            model_push(w);
        end
        rd_chk("status_overflow", 8'h01, exp_status());
        check("int_masked", bus.int_rx_host, 1'b0);
        wr(8'h01, 8'h04);
        model_ovf = 1'b0;
        rd_chk("status_ovf_clr", 8'h01, exp_status());
        wr(8'h00, 8'h03);
        rd_chk("ctrl_03", 8'h00, 8'h03);
        check("int_unmasked", bus.int_rx_host, 1'b1);

        // full FIFO: pop in the same cycle as the push
        restart(8'h03);
        w = 16'($urandom);
        send_frame(w);
        bus.ADDRESS = 8'h05; bus.read_enable = 1'b1;
        @(negedge clk);
        bus.read_enable = 1'b0;
        check("full_pop_hi", bus.DATA_OUT, model_q[0][15:8]);
        void'(model_q.pop_front());
        model_q.push_back(w);
        rd_chk("status_full_swap", 8'h01, exp_status());
        while (model_q.size() > 0) pop_chk("drain");
        rd_chk("status_empty", 8'h01, exp_status());

        // empty FIFO: same-cycle pop is ignored, push accepted
        restart(8'h03);
        w = 16'($urandom);
        send_frame(w);
        bus.ADDRESS = 8'h05; bus.read_enable = 1'b1;
        @(negedge clk);
        bus.read_enable = 1'b0;
        model_push(w);
        rd_chk("status_empty_push", 8'h01, exp_status());
        pop_chk("empty_push");

        // partial frame discarded on disable
        restart(8'h03);
        send_bits(16'h0000, 2);
        send_bits(16'h00A5, 8);
        send_bits(16'($urandom), 6);
        wr(8'h00, 8'h02);
        restart(8'h03);
        send_frame(16'hBEEF);
        model_push(16'hBEEF);
        rd_chk("status_abort", 8'h01, exp_status());
        rd_chk("abort_lo", 8'h04, 8'hEF);
        wr(8'h00, 8'h07);
        model_q.delete();
        rd_chk("status_flushed", 8'h01, exp_status());
        rd_chk("ctrl_after_flush", 8'h00, 8'h03);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bd_rx_core.md
Name: bd_rx_core

Overview:
- Parametrised next-generation baseband receive core. Replaces the fixed 8-bit demodulator/decoder/register-field chain.
- Slices oversampled ADC samples into bits by majority vote, hunts for a programmable sync byte, then assembles fixed-length frames.
- Completed frames are buffered in an RX FIFO that the host drains through a byte-wide register interface; an interrupt is raised to the host.

Parameters:
- ADC_W, 8: ADC sample width, must be >= 8; threshold compares against ADC[ADC_W-1 -: 8].
- OVERSAMPLE, 8: clock cycles per bit, must be >= 3.
- FRAME_BITS, 16: payload bits per frame, range 1..16; zero-extended to 16 in the FIFO.
- FIFO_DEPTH, 4: frame FIFO entries, range 2..15.

Ports:
- G_CLK_RX  in  1  receive clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ADC  in  ADC_W  sampled input signal, one sample per clock.
- ADDRESS  in  8  register address.
- DATA_IN  in  8  register write data.
- write_enable  in  1  register write strobe, one cycle.
- read_enable  in  1  register read strobe, one cycle.
- DATA_OUT  out  8  registered read data.
- int_rx_host  out  1  level interrupt to host.

Behaviour:
- Reset (reset=0, async): CTRL=0x00, THRESH=0x80, SYNC=0xA5, FIFO empty, overflow=0, FSM=IDLE, DATA_OUT=0x00, int_rx_host=0.
- Register map:
  - 0x00 CTRL RW: b0 RX_ENABLE, b1 INT_EN, b2 FLUSH. FLUSH is write-only and self-clearing; it always reads 0.
  - 0x01 STATUS: b0 not_empty, b1 full, b2 overflow (sticky; writing 1 to b2 clears it), b7:4 count. All other bits are RO.
  - 0x02 THRESH RW.
  - 0x03 SYNC RW.
  - 0x04 DATA_LO RO: FIFO head [7:0], no pop.
  - 0x05 DATA_HI RO: FIFO head [15:8]. read_enable at 0x05 with FIFO non-empty pops the head.
  - Unmapped addresses read 0x00; writes to RO or unmapped addresses are ignored.
- Read latency: DATA_OUT is updated at the edge after the cycle ADDRESS is presented, whether or not read_enable is asserted. A DATA_HI read returns the pre-pop value.
- Slicer:
  - Runs only while RX_ENABLE=1.
  - Per sample: hit = (ADC top byte >= THRESH), unsigned compare.
  - Phase counter 0..OVERSAMPLE-1 counts hits. At the phase wrap, bit = (hits > OVERSAMPLE/2, integer division), a bit_valid pulse is issued, and hits are cleared.
  - The phase counter restarts at 0 on the 0->1 transition of RX_ENABLE.
- FSM:
  - IDLE: RX_ENABLE=0. On RX_ENABLE=1, go to HUNT with the 8-bit shift register cleared.
  - HUNT: each bit_valid shifts the bit in at the LSB. When the shift register equals SYNC after a shift, go to DATA with bit count 0.
  - DATA: bits shift in MSB first. On the FRAME_BITS-th bit, push the word and return to HUNT with the shift register cleared.
  - RX_ENABLE=0 in any state goes to IDLE next cycle; a partial frame is discarded.
  - FLUSH in HUNT or DATA restarts HUNT with the shift register cleared.
- FIFO:
  - Push when full: the word is dropped and overflow is set.
  - Push and pop in the same cycle when full: both take effect; count is unchanged and no overflow.
  - Push and pop in the same cycle when empty: the push is accepted; the pop is ignored.
  - FLUSH empties the FIFO in 1 cycle; overflow is unchanged. FLUSH has priority over a same-cycle push or pop.
- Interrupt: int_rx_host is registered = INT_EN & (not_empty | overflow). It is asserted 1 cycle after the push edge and deasserted 1 cycle after the condition clears.
- CTRL and THRESH writes take effect on the next sample.

Test Plan:
- Reset then read 0x00..0x05 and 0x07 -> DATA_OUT 0x00, 0x00, 0x80, 0xA5, 0x00, 0x00, 0x00; int_rx_host=0.
- Defaults, CTRL=0x03, ADC stream (8 cycles/bit, 0xFF=1, 0x00=0): bits 10100101 then 0x1234 MSB first -> STATUS=0x11 and int_rx_host=1 within 2 cycles of the last bit; read 0x04 -> 0x34; read 0x05 -> 0x12 and pop; STATUS=0x00; int_rx_host=0.
- Bit with 4 of 8 samples 0xFF -> sliced 0; 5 of 8 -> sliced 1. THRESH=0xC0 with ADC=0xBF -> 0.
- Send 5 frames with FIFO_DEPTH=4 and no reads -> STATUS=0x47; the 5th frame is lost. Write STATUS 0x04 -> overflow cleared, STATUS=0x43.
- Full FIFO with pop at 0x05 in the same cycle as the next push -> count stays 4, overflow=0, and the new word is the tail.
- Clear RX_ENABLE 6 bits into a frame, re-enable, send sync plus 0xBEEF -> only 0xBEEF is in the FIFO. Write CTRL=0x07 -> FIFO empty and CTRL reads 0x03.
